uart_tx_serializer: RTL and testbench

UART transmitter: accepts a parallel word on a valid strobe, then serializes a frame on TX_OUT, one bit per CLK cycle: start bit, data LSB-first, optional parity, one stop bit. CLK is the TX baud-rate clock. It pairs with the receive path's sampler, parity checker and stop checker, and produces frames those blocks accept without error.

---
 rtl/uart_tx_serializer_if.sv | 41 ++++
 rtl/uart_tx_serializer.sv | 136 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Purpose: request/serial-line bundle between a UART TX client and uart_tx_serializer.
// Latency: none, wires only.
// Backpressure: busy high means data_valid is ignored; the client re-presents after busy drops.
//
// Signals:
//   p_data     parallel payload, sampled when the serializer accepts
//   data_valid level-sensitive send request
//   par_en     1 = append a parity bit to the frame
//   par_typ    0 = even parity, 1 = odd parity
//   tx_out     serial line, idles high
//   busy       high while a frame is on the line
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  tx_out;
    logic                  busy;

    // Client side: issues requests, watches the line.
    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        input  tx_out,
        input  busy
    );

    // Serializer side.
    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output tx_out,
        output busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Purpose: UART frame serializer: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Latency: start bit appears on tx_out one clk after acceptance; one bit per clk (clk is the baud clock).
// Backpressure: no buffering; data_valid is only honoured in IDLE, busy tells the client when to retry.
//
// Ports:
//   clk   baud-rate clock, all state changes on its rising edge
//   rst   asynchronous active-high reset; aborts any frame and forces the line high at once
//   bus   uart_tx_serializer_if.slave: p_data, data_valid, par_en, par_typ in; tx_out, busy out
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q,   state_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;

    // State register. tx_out and busy are plain flops so the line never
    // sees a combinational path from the request inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic. tx_d/busy_d describe what the line shows while in
    // state_d, so each branch sets them for the state it is entering.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    // Capture everything the frame needs now, so later
                    // changes on the request inputs cannot reach the line.
                    state_d   = START;
                    shift_d   = bus.p_data;
                    cnt_d     = '0;
                    par_en_d  = bus.par_en;
                    par_bit_d = (^bus.p_data) ^ bus.par_typ;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            START: begin
                // First data bit goes out; cnt counts bits already shown.
                state_d = DATA;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end

            DATA: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            PARITY: begin
                state_d = STOP;
                tx_d    = 1'b1;
                busy_d  = 1'b1;
            end

            STOP: begin
                // Always pass through one IDLE cycle before the next
                // acceptance, giving a two-bit-time high gap between frames.
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end

            default: begin
                // Unused encodings fall back to a quiet line.
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of line bits still owed for the current frame.
    bit   exp_q[$];
    logic exp_tx    = 1'b1;
    logic exp_busy  = 1'b0;
    logic prev_busy = 1'b0;

    // Line history as observed, one entry per clock, for directed checks.
    logic tx_hist[$];
    logic busy_hist[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge of the behavioural model: a frame is the list of bits
    // start, data LSB first, optional parity, stop. A new one may only begin
    // after a clock in which the line was not busy.
    task automatic model_edge();
        int ones;
        if (exp_q.size() > 0) begin
            exp_tx   = exp_q.pop_front();
            exp_busy = 1'b1;
        end else if (!prev_busy && bus.data_valid) begin
            ones = 0;
            exp_q.push_back(1'b0);
            for (int i = 0; i < DW; i++) begin
                exp_q.push_back(bus.p_data[i]);
                if (bus.p_data[i]) ones++;
            end
            if (bus.par_en)
                exp_q.push_back(((ones % 2) == 1) ^ bus.par_typ);
            exp_q.push_back(1'b1);
            exp_tx   = exp_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
        prev_busy = exp_busy;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_tx    = 1'b1;
        exp_busy  = 1'b0;
        prev_busy = 1'b0;
    endtask

    // Advance one clock, compare against the model on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val({tag, "_tx"}, bus.tx_out, exp_tx);
        check_val({tag, "_busy"}, bus.busy, exp_busy);
        tx_hist.push_back(bus.tx_out);
        busy_hist.push_back(bus.busy);
    endtask

    task automatic set_req(input logic dv, input logic [DW-1:0] d, input logic pe, input logic pt);
        bus.data_valid = dv;
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
    endtask

    function automatic int busy_count();
        int n = 0;
        foreach (busy_hist[i]) if (busy_hist[i]) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] data_from_hist(input int first);
        logic [DW-1:0] v;
        for (int i = 0; i < DW; i++) v[i] = tx_hist[first + i];
        return v;
    endfunction

    task automatic clear_hist();
        tx_hist.delete();
        busy_hist.delete();
    endtask

    initial begin
        logic [9:0] seq;
        int starts[$];
        int run;

        rst = 1'b1;
        set_req(1'b0, '0, 1'b0, 1'b0);
        #1;
        check_val("reset_tx", bus.tx_out, 1'b1);
        check_val("reset_busy", bus.busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick("idle");

        // 0xA5, no parity, single-cycle request.
        clear_hist();
        set_req(1'b1, 8'hA5, 1'b0, 1'b0);
        tick("a5_np");
        bus.data_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick("a5_np");
        for (int i = 0; i < 10; i++) seq[i] = tx_hist[i];
        check_val("a5_np_seq", seq, 10'b1101001010);
        check_val("a5_np_busy_len", busy_count(), 10);

        // 0xA5 with even then odd parity.
        for (int t = 0; t < 2; t++) begin
            clear_hist();
            set_req(1'b1, 8'hA5, 1'b1, t[0]);
            tick("a5_par");
            bus.data_valid = 1'b0;
            for (int i = 0; i < 13; i++) tick("a5_par");
            check_val("a5_par_bit", tx_hist[9], t[0]);
            check_val("a5_par_busy_len", busy_count(), 11);
        end

        // 0x80 even parity: parity bit must be 1.
        clear_hist();
        set_req(1'b1, 8'h80, 1'b1, 1'b0);
        tick("x80");
        bus.data_valid = 1'b0;
        for (int i = 0; i < 13; i++) tick("x80");
        check_val("x80_data", data_from_hist(1), 8'h80);
        check_val("x80_parity", tx_hist[9], 1'b1);
        check_val("x80_stop", tx_hist[10], 1'b1);

        // 0x3C with a second request and input churn during data bit 3.
        clear_hist();
        set_req(1'b1, 8'h3C, 1'b0, 1'b0);
        tick("x3c");
        set_req(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick("x3c");
        set_req(1'b1, 8'hFF, 1'b1, 1'b1);
        tick("x3c");
        set_req(1'b0, 8'h12, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) tick("x3c");
        check_val("x3c_data", data_from_hist(1), 8'h3C);
        check_val("x3c_busy_len", busy_count(), 10);

        // Request held high: frames back to back with a two-cycle high gap.
        clear_hist();
        set_req(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) tick("b2b");
        bus.data_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick("b2b_drain");
        for (int i = 0; i < busy_hist.size(); i++)
            if (busy_hist[i] && (i == 0 || !busy_hist[i-1])) starts.push_back(i);
        check_val("b2b_frames", starts.size() >= 3, 1'b1);
        if (starts.size() >= 3) begin
            check_val("b2b_period1", starts[1] - starts[0], DW + 3);
            check_val("b2b_period2", starts[2] - starts[1], DW + 3);
            run = 0;
            for (int i = starts[1] - 1; i >= 0 && tx_hist[i]; i--) run++;
            check_val("b2b_gap", run, 2);
        end

        // Reset in the middle of data bit 4 of 0x0F.
        clear_hist();
        set_req(1'b1, 8'h0F, 1'b0, 1'b0);
        tick("rst_mid");
        bus.data_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick("rst_mid");
        check_val("rst_mid_bit4", tx_hist[5], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_mid_async_tx", bus.tx_out, 1'b1);
        check_val("rst_mid_async_busy", bus.busy, 1'b0);
        model_reset();
        @(negedge clk);
        check_val("rst_hold_tx", bus.tx_out, 1'b1);
        check_val("rst_hold_busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick("post_rst");
        clear_hist();
        set_req(1'b1, 8'h0F, 1'b0, 1'b0);
        tick("post_rst");
        bus.data_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick("post_rst");
        check_val("post_rst_start", tx_hist[0], 1'b0);
        check_val("post_rst_data", data_from_hist(1), 8'h0F);
        check_val("post_rst_busy_len", busy_count(), 10);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_req($urandom_range(0, 2) == 0, DW'($urandom), 1'($urandom), 1'($urandom));
            tick("rand");
        end
        bus.data_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
